mc_controller: RTL
==================

Name: mc_controller

Overview:
- Moore-style control FSM that sequences the multicycle MIPS datapath: shared memory, IR, register file, ALU, and the immediate sign extender.
- Decodes op/funct from the instruction register and drives per-cycle control strobes.
- ALU-operation decode lives in a small combinational sub-module.
- Sits beside the datapath in the multicycle top level, replacing the single-cycle combinational controller.

Parameters:
- OP_W, 6, opcode field width
- FUNCT_W, 6, funct field width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FETCH
- op  in  OP_W  IR[31:26]
- funct  in  FUNCT_W  IR[5:0]
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = Data register
- regwrite  out  1  register-file write
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = const 4, 10 = extended imm, 11 = extended imm << 2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- immsrc  out  1  0 = sign-extend imm, 1 = zero-extend
- illegal_op  out  1  one-cycle pulse in DECODE on an unrecognised opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-high. While reset is asserted, state = FETCH.
- Output model: all outputs are combinational from the registered state (plus zero for pcen, and op/funct for alucontrol).
- Reset output values (FETCH decode): iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcen=1; memwrite=regwrite=regdst=memtoreg=immsrc=illegal_op=0.
- Reset mid-instruction: the instruction is abandoned and FETCH takes effect immediately. No partial write may occur after reset is sampled high.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Transitions:
  - FETCH -> DECODE (irwrite=1, pcwrite=1, PC+4)
  - DECODE (alusrca=0, alusrcb=11, add: branch-target precompute) -> by op:
    - LW 100011 / SW 101011 -> MEMADR
    - RTYPE 000000 -> RTEXEC
    - BEQ 000100 -> BRANCH
    - ADDI 001000 -> ADDIEXEC
    - J 000010 -> JUMP
    - any other opcode -> FETCH with illegal_op=1 (executed as a NOP)
  - MEMADR (alusrca=1, alusrcb=10, add) -> MEMRD if LW, MEMWR if SW
  - MEMRD (iord=1) -> MEMWB (regdst=0, memtoreg=1, regwrite=1) -> FETCH
  - MEMWR (iord=1, memwrite=1) -> FETCH
  - RTEXEC (alusrca=1, alusrcb=00, funct decode) -> ALUWB (regdst=1, memtoreg=0, regwrite=1) -> FETCH
  - BRANCH (alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1) -> FETCH
  - ADDIEXEC (alusrca=1, alusrcb=10, add) -> ADDIWB (regdst=0, memtoreg=0, regwrite=1) -> FETCH
  - JUMP (pcsrc=10, pcwrite=1) -> FETCH
- pcen = pcwrite | (branch & zero).
- Instruction latency in cycles including FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
- Unused state encodings 12..15 (when the optional feature is absent) return to FETCH on the next edge with all strobes deasserted.
- ALU decode, aluop internal 2 bits:
  - 00 -> add
  - 01 -> sub
  - 10 -> funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> add
  - 11 -> logical immediate (optional feature only)

Optional Feature:
- Macro: MC_ZERO_EXT_IMM_EN.
- Defined:
  - Adds states LOGIEXEC=12 and LOGIWB=13.
  - DECODE routes ORI 001101 and ANDI 001100 to LOGIEXEC.
  - LOGIEXEC: alusrca=1, alusrcb=10, immsrc=1, aluop=11; alucontrol = or for ORI, and for ANDI.
  - LOGIWB: regdst=0, memtoreg=0, regwrite=1, immsrc=1 -> FETCH.
- Undefined: immsrc tied 0; ORI and ANDI are illegal opcodes; encodings 12..15 are unused.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum, 4-bit
  - opcode constants
  - funct constants
  - aluop and alucontrol encodings
  - alusrcb and pcsrc select encodings
- Sub-module mc_aludec: combinational; inputs aluop, funct, op; output alucontrol.
- The FSM and output decode stay in mc_controller.

Test Plan:
- Reset asserted asynchronously mid-MEMWR of SW -> same cycle: state_dbg=0, memwrite=0, irwrite=1, pcen=1.
- LW (op=100011) -> states 0,1,2,3,4,0; iord=1 in states 3 and 4; regwrite=1 only in state 4; memtoreg=1.
- R-type SLT (funct=101010) -> RTEXEC alucontrol=111; ALUWB regdst=1, regwrite=1; next FETCH after 4 cycles.
- BEQ with zero=1 -> pcen=1 in BRANCH, pcsrc=01. Same with zero=0 -> pcen=0 in BRANCH. Both cases return to FETCH.
- op=111111 -> DECODE pulses illegal_op=1 for one cycle, then FETCH; no regwrite or memwrite at any point.
- With MC_ZERO_EXT_IMM_EN, ORI (op=001101) -> states 0,1,12,13; immsrc=1, alucontrol=001. Without the macro, ORI -> illegal_op=1, immsrc=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS controller (MC_ZERO_EXT_IMM_EN adds LOGIEXEC/LOGIWB)
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTEXEC   = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    LOGIEXEC = 4'd12,
    LOGIWB   = 4'd13
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_LOGI} aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps aluop plus funct/op fields to the 3-bit ALU control
module mc_aludec
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  aluop_t             aluop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [OP_W-1:0]    op,
  output logic [2:0]         alucontrol
);
  logic [2:0] fn_ctl;
  always_comb begin
    fn_ctl = funct == FN_SUB ? ALU_SUB :
             funct == FN_AND ? ALU_AND :
             funct == FN_OR  ? ALU_OR  :
             funct == FN_SLT ? ALU_SLT : ALU_ADD;
    alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                 aluop == ALUOP_FUNCT ? fn_ctl :
                 aluop == ALUOP_LOGI  ? (op == OP_ORI ? ALU_OR : ALU_AND) : ALU_ADD;
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the multicycle MIPS datapath.
// Define MC_ZERO_EXT_IMM_EN to add zero-extended ORI/ANDI (LOGIEXEC/LOGIWB).
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               immsrc,
  output logic               illegal_op,
  output logic [3:0]         state_dbg
);
  state_t state, next;
  aluop_t aluop;
  logic pcwrite, branch;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else       state <= next;
  always_comb begin
    next       = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PC_ALU;
    aluop      = ALUOP_ADD;
    immsrc     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        next    = DECODE;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = SRCB_4;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = RTEXEC;
          OP_BEQ:       next = BRANCH;
          OP_ADDI:      next = ADDIEXEC;
          OP_J:         next = JUMP;
`ifdef MC_ZERO_EXT_IMM_EN
          OP_ORI, OP_ANDI: next = LOGIEXEC;
`endif
          default:      illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        next    = op == OP_SW ? MEMWR : MEMRD;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        next = MEMWB;
        iord = 1'b1;
      end
      MEMWB: begin
        iord     = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTEXEC: begin
        next    = ALUWB;
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        next    = ADDIWB;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
`ifdef MC_ZERO_EXT_IMM_EN
      LOGIEXEC: begin
        next    = LOGIWB;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        immsrc  = 1'b1;
        aluop   = ALUOP_LOGI;
      end
      LOGIWB: begin
        regwrite = 1'b1;
        immsrc   = 1'b1;
      end
`endif
      default: ;
    endcase
  end
  // BEQ redirects the PC only when the ALU subtraction reports equality
  assign pcen      = pcwrite | (branch & zero);
  assign state_dbg = state;
  mc_aludec #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .op         (op),
    .alucontrol (alucontrol)
  );
endmodule
